// File: rtl/frogger_pkg.sv
// frogger_pkg: shared BCD time types, default best time and tracker FSM states
package frogger_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam int TIME_DIGITS = 6;
   localparam logic [23:0] DEFAULT_BEST = 24'h595959;
   typedef enum logic [1:0] {IDLE, COMPARE, UPDATE} bt_state_t;
   // index 0 is hr_10s (most significant), 5 is sec_1s
   function automatic bcd_digit_t digit_sel(input logic [23:0] t, input logic [2:0] i);
      return bcd_digit_t'(t >> (5'd20 - {i, 2'b00}));
   endfunction
endpackage

// File: rtl/bcd_digit_cmp.sv
// bcd_digit_cmp: compares one candidate BCD digit against a reference digit
module bcd_digit_cmp (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       lt,
   output logic       gt,
   output logic       eq,
   output logic       invalid
);
   assign invalid = a > 4'd9;
   assign lt = !invalid && a < b;
   assign gt = !invalid && a > b;
   assign eq = !invalid && a == b;
endmodule

// File: rtl/best_time_tracker.sv
// best_time_tracker: snapshots the elapsed time on each win and keeps the fastest, one BCD digit compared per cycle.
// Define BEST_CLEAR_EN to add a clear_best input that restores INIT_BEST and aborts any compare in flight.
module best_time_tracker
   import frogger_pkg::*;
#(
   parameter logic [23:0] INIT_BEST  = DEFAULT_BEST,
   parameter int          NUM_DIGITS = TIME_DIGITS
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        is_win,
   input  logic [23:0] cur_time,
`ifdef BEST_CLEAR_EN
   input  logic        clear_best,
`endif
   output logic [23:0] best_time,
   output logic        new_record,
   output logic        busy
);
   bt_state_t state, state_nx;
   logic win_q, win_rise, clr, last, lt, gt, eq, invalid, load_snap, step_idx, do_update;
   logic [23:0] snapshot;
   logic [2:0] idx;
   logic [3:0] snap_d, best_d;
`ifdef BEST_CLEAR_EN
   assign clr = clear_best;
`else
   assign clr = 1'b0;
`endif
   assign win_rise = is_win & ~win_q;
   assign last = idx == 3'(NUM_DIGITS - 1);
   assign snap_d = digit_sel(snapshot, idx);
   assign best_d = digit_sel(best_time, idx);

   bcd_digit_cmp u_cmp (
      .a       (snap_d),
      .b       (best_d),
      .lt      (lt),
      .gt      (gt),
      .eq      (eq),
      .invalid (invalid)
   );

   always_ff @(posedge clk_100MHz or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (clr) state_nx = IDLE;
      else
         case (state)
            IDLE:    state_nx = win_rise ? COMPARE : IDLE;
            COMPARE: state_nx = lt ? UPDATE : (invalid || gt || last) ? IDLE : COMPARE;
            default: state_nx = IDLE;
         endcase
   end

   always_comb begin
      load_snap = state == IDLE && win_rise && !clr;
      step_idx = state == COMPARE && eq && !last;
      do_update = state == UPDATE && !clr;
   end

   // equal times fall through to IDLE on the last digit, so only strictly faster times reach UPDATE
   always_ff @(posedge clk_100MHz or negedge reset)
      if (!reset) begin
         best_time <= INIT_BEST;
         new_record <= 1'b0;
         busy <= 1'b0;
         win_q <= 1'b0;
         snapshot <= '0;
         idx <= '0;
      end else begin
         win_q <= is_win;
         busy <= state_nx != IDLE;
         new_record <= do_update;
         if (load_snap) snapshot <= cur_time;
         idx <= load_snap ? 3'd0 : step_idx ? idx + 3'd1 : idx;
         if (clr) best_time <= INIT_BEST;
         else if (do_update) best_time <= snapshot;
      end
endmodule

// File: tb/tb_best_time_tracker.sv
// tb_best_time_tracker: randomized scoreboard bench for best_time_tracker; honours BEST_CLEAR_EN when defined
module tb_best_time_tracker;
   localparam logic [23:0] INIT = 24'h595959;
   logic clk_100MHz = 0, reset = 0, is_win = 0, new_record, busy;
   logic [23:0] cur_time = '0, best_time;
`ifdef BEST_CLEAR_EN
   logic clear_best = 0;
`endif
   typedef struct { bit rec; logic [23:0] best; int len; } exp_t;
   exp_t q[$];
   exp_t me;
   int total = 0, bad = 0, run = 0, m_left = 0;
   logic [23:0] m_best = INIT;
   bit m_win = 0;

   best_time_tracker dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .is_win     (is_win),
      .cur_time   (cur_time),
`ifdef BEST_CLEAR_EN
      .clear_best (clear_best),
`endif
      .best_time  (best_time),
      .new_record (new_record),
      .busy       (busy)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // MSD-first scan: the first digit that is invalid or differs decides the outcome
   function automatic void judge(input logic [23:0] s, input logic [23:0] b, output bit rec, output int k);
      logic [3:0] sd, bd;
      rec = 0;
      k = 5;
      for (int i = 0; i < 6; i++) begin
         sd = 4'(s >> (20 - 4 * i));
         bd = 4'(b >> (20 - 4 * i));
         if (sd > 9 || sd != bd) begin
            rec = sd <= 9 && sd < bd;
            k = i;
            return;
         end
      end
   endfunction

   task automatic model_step();
      bit rec, rise;
      int k;
      exp_t e;
      if (!reset) begin
         m_best = INIT;
         m_win = 0;
         m_left = 0;
         q.delete();
         return;
      end
      rise = is_win && !m_win;
      m_win = is_win;
`ifdef BEST_CLEAR_EN
      if (clear_best) begin
         if (m_left > 0) begin
            e = q.pop_back();
            e.rec = 0;
            e.best = INIT;
            e.len = e.len - m_left + 1;
            q.push_back(e);
         end
         m_best = INIT;
         m_left = 0;
         return;
      end
`endif
      if (m_left > 0) m_left--;
      else if (rise) begin
         judge(cur_time, m_best, rec, k);
         e.rec = rec;
         e.best = rec ? cur_time : m_best;
         e.len = rec ? k + 2 : k + 1;
         q.push_back(e);
         if (rec) m_best = cur_time;
         m_left = e.len;
      end
   endtask

   task automatic tick();
      @(posedge clk_100MHz);
      model_step();
      #1;
   endtask

   task automatic win(input logic [23:0] t, input int hi);
      cur_time = t;
      is_win = 1;
      repeat (hi) tick();
      is_win = 0;
      repeat (10) tick();
   endtask

   function automatic logic [23:0] rand_time();
      logic [23:0] t;
      int sh, r;
      r = $urandom_range(0, 9);
      sh = 4 * $urandom_range(0, 5);
      t = m_best;
      if (r < 4) for (int i = 0; i < 6; i++) t = {t[19:0], 4'($urandom_range(0, 9))};
      else if (r < 8) begin
         if (4'(t >> sh) != 4'd0 && 4'(t >> sh) <= 4'd9 && r < 7) t = t - (24'h1 << sh);
      end else t = (t & ~(24'hF << sh)) | (24'($urandom_range(10, 15)) << sh);
      return t;
   endfunction

   initial forever begin
      @(negedge clk_100MHz);
      if (!reset) run = 0;
      else if (busy) run++;
      else if (run > 0) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: busy ran %0d cycles with no capture expected", run);
         end else begin
            me = q.pop_front();
            check("new_record", 32'(new_record), 32'(me.rec));
            check("best_time", 32'(best_time), 32'(me.best));
            check("busy_len", run, me.len);
         end
         run = 0;
      end else if (new_record) begin
         total++;
         bad++;
         $display("FAIL spurious_new_record: got 1 expected 0 at %0t", $time);
      end
   end

   initial begin
      repeat (2) tick();
      check("rst_best", 32'(best_time), 32'(INIT));
      check("rst_busy", 32'(busy), 0);
      check("rst_new_record", 32'(new_record), 0);
      reset = 1;
      repeat (2) tick();
      win(24'h000130, 1);
      check("best_000130", 32'(best_time), 32'h000130);
      win(24'h000145, 1);
      win(24'h000130, 1);
      win(24'h000129, 1);
      win(24'h000128, 1);
      win(24'h0001A0, 1);
      check("best_after_invalid", 32'(best_time), 32'h000128);
      cur_time = 24'h000100;
      is_win = 1;
      tick();
      is_win = 0;
      tick();
      cur_time = 24'h000000;
      is_win = 1;
      tick();
      is_win = 0;
      repeat (12) tick();
      check("busy_rise_ignored", 32'(best_time), 32'h000100);
      win(24'h000059, 100);
      check("held_high_single", 32'(best_time), 32'h000059);
      cur_time = 24'h000000;
      is_win = 1;
      repeat (3) tick();
      reset = 0;
      #1;
      check("async_rst_best", 32'(best_time), 32'(INIT));
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_new_record", 32'(new_record), 0);
      is_win = 0;
      repeat (3) tick();
      is_win = 1;
      cur_time = 24'h000200;
      tick();
      reset = 1;
      repeat (3) tick();
      is_win = 0;
      repeat (8) tick();
      check("first_cycle_capture", 32'(best_time), 32'h000200);
`ifdef BEST_CLEAR_EN
      clear_best = 1;
      cur_time = 24'h000100;
      is_win = 1;
      tick();
      clear_best = 0;
      is_win = 0;
      check("clear_vs_rise_best", 32'(best_time), 32'(INIT));
      check("clear_vs_rise_busy", 32'(busy), 0);
      repeat (3) tick();
      cur_time = 24'h590000;
      is_win = 1;
      tick();
      is_win = 0;
      tick();
      clear_best = 1;
      tick();
      clear_best = 0;
      repeat (8) tick();
      check("clear_abort_best", 32'(best_time), 32'(INIT));
`endif
      for (int n = 0; n < 80; n++) begin
         if (n % 20 == 19) begin
            reset = 0;
            repeat (2) tick();
            reset = 1;
            tick();
         end
`ifdef BEST_CLEAR_EN
         if ($urandom_range(0, 9) == 0) begin
            clear_best = 1;
            tick();
            clear_best = 0;
         end
`endif
         cur_time = rand_time();
         is_win = 1;
         repeat ($urandom_range(1, 8)) begin
            tick();
            if ($urandom_range(0, 3) == 0) cur_time = $urandom;
         end
         is_win = 0;
         repeat ($urandom_range(1, 9)) tick();
      end
      repeat (20) tick();
      check("pending_expectations", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
